// File: rtl/quot_bcd_conv.sv
// Signed quotient to sign + packed BCD converter for the divider's output stage.
// Sequential double-dabble: one magnitude bit per clock with a start/busy/done handshake.
module quot_bcd_conv #(
  parameter int unsigned W      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          din,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [BW+W-1:0] r_sr;       // {BCD accumulator, magnitude} shifted as one word
  logic [CW-1:0]   r_cnt;
  logic            r_neg_cap;
  logic            r_neg;
  logic [BW-1:0]   r_bcd;

  logic [W-1:0]    w_mag;
  logic [BW-1:0]   w_adj;
  logic [BW+W-1:0] w_sr_next;
  logic            w_last;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) without overflow.
  assign w_mag  = din[W-1] ? ((~din) + W'(1)) : din;
  assign w_last = (r_cnt == CW'(W - 1));

  always_comb begin
    w_adj = r_sr[BW+W-1:W];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_sr[W + 4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_sr[W + 4*i +: 4] + 4'd3;
    end
  end

  assign w_sr_next = {w_adj, r_sr[W-1:0]} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_neg_cap <= 1'b0;
      r_neg     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CW'(1);
          // Result registers load on the edge entering DONE, so they are valid with done.
          if (w_last) begin
            r_state <= S_DONE;
            r_bcd   <= w_sr_next[BW+W-1:W];
            r_neg   <= r_neg_cap;
          end
        end
        default: begin
          if (start) begin
            r_neg_cap <= din[W-1];
            r_sr      <= {{BW{1'b0}}, w_mag};
            r_cnt     <= '0;
            r_state   <= S_SHIFT;
          end else begin
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign neg  = r_neg;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_quot_bcd_conv.sv
// Directed + randomized bench for quot_bcd_conv against an arithmetic decimal-digit model.
module tb_quot_bcd_conv;

  localparam int unsigned W      = 16;
  localparam int unsigned DIGITS = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [W-1:0]        din;
  logic                busy;
  logic                done;
  logic                neg;
  logic [4*DIGITS-1:0] bcd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  quot_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] ref_bcd(input int v);
    int m;
    logic [19:0] r;
    m = (v < 0) ? -v : v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns likewise.
  task automatic run_conv(input int v, input string tag);
    int          n;
    int          busy_n;
    bit          got;
    logic [19:0] e_bcd;
    e_bcd  = ref_bcd(v);
    din    = 16'(v);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    busy_n = busy ? 1 : 0;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 40) begin
      din   = 16'($urandom);
      start = (n < 10) ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
    check({tag, "_neg"}, 32'(neg), 32'(v < 0));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_bcd_hold"}, 32'(bcd), 32'(e_bcd));
  endtask

  initial begin
    int          vals [4];
    int          n;
    int          seen;
    int          last_done;
    int          v;
    bit          got;
    logic [15:0] rr;

    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg",  32'(neg),  32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    run_conv(25,     "d25");
    run_conv(5,      "d5");
    run_conv(-1,     "dm1");
    run_conv(32767,  "dmax");
    run_conv(-32768, "dmin");
    run_conv(0,      "dzero");

    // Start held high, din alternating; each result must reflect din at its accept edge.
    vals = '{7, -301, 7, -301};
    last_done = 0;
    din   = 16'(vals[0]);
    start = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      if (r < 3) din = 16'(vals[r+1]);
      else begin din = 16'(1234); start = 1'b0; end
      check("b2b_busy", 32'(busy), 32'd1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (done) got = 1'b1;
      end
      check("b2b_done_seen", 32'(got), 32'd1);
      if (r > 0) check("b2b_gap", 32'(cyc - last_done), 32'd17);
      last_done = cyc;
      check("b2b_bcd", 32'(bcd), 32'(ref_bcd(vals[r])));
      check("b2b_neg", 32'(neg), 32'(vals[r] < 0));
      if (r < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("b2b_end_busy", 32'(busy), 32'd0);
    check("b2b_end_done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    din   = 16'(1762);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd",  32'(bcd),  32'd0);
    check("arst_neg",  32'(neg),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    run_conv(4, "after_rst");

    // Quotients as the divider would produce them.
    run_conv(301 / 39,     "div_301_39");
    run_conv(8934 / 1942,  "div_8934_1942");
    run_conv(18543 / 5000, "div_18543_5000");

    for (int k = 0; k < 12; k++) begin
      rr = 16'($urandom);
      v  = int'($signed(rr));
      run_conv(v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
